jtag_debug_ocimem: RTL and testbench

- Debug-side on-chip memory engine, directly downstream of the JTAG debug module's system-clock stage.
- Consumes the synchronized `jdo` command word and the `take_*_ocimem` pulses. Performs reads and writes on a private 2^ADDR_W x 32 debug RAM.
- Returns read data and status to the JTAG stage as `MonDReg`, `monitor_ready` and `monitor_error`.
- Also exposes the same RAM to the CPU through an Avalon-MM slave port, with JTAG having priority.

---
 rtl/jtag_debug_ocimem.sv | 139 +++++++++++++
 tb/tb_jtag_debug_ocimem.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_ocimem.sv
// Debug-side on-chip memory engine: services JTAG monitor reads/writes on a private
// debug RAM and shares that RAM with the CPU through an Avalon-MM slave (JTAG first).
module jtag_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   MonAReg;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic [31:0]         ram_q;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata;

    logic                jtag_wr;
    logic                jtag_ld;
    logic                jtag_nxt;
    logic                jtag_any;
    logic [ADDR_W-1:0]   jdo_addr;
    logic [ADDR_W-1:0]   mon_inc;
    logic                jdo_unused;

    // Only one pulse is honoured: write beats load beats read-next.
    assign jtag_wr    = take_action_ocimem_b;
    assign jtag_ld    = take_action_ocimem_a & ~take_action_ocimem_b;
    assign jtag_nxt   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign jtag_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign jdo_addr   = jdo[ADDR_W+9:10];
    assign mon_inc    = MonAReg + ADDR_W'(1);
    assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        ram_we          = 1'b0;
        ram_addr        = MonAReg;
        ram_wdata       = jdo[34:3];
        avs_waitrequest = 1'b0;
        case (state)
            IDLE: begin
                if (jtag_wr) begin
                    ram_we          = 1'b1;
                    avs_waitrequest = 1'b1;
                end else if (jtag_ld) begin
                    ram_addr        = jdo_addr;
                    avs_waitrequest = 1'b1;
                end else if (jtag_nxt) begin
                    ram_addr        = mon_inc;
                    avs_waitrequest = 1'b1;
                end else if (avs_read) begin
                    ram_addr        = avs_address;
                    avs_waitrequest = 1'b1;
                end else if (avs_write) begin
                    ram_we          = 1'b1;
                    ram_addr        = avs_address;
                    ram_wdata       = avs_writedata;
                end
            end
            JRD:     avs_waitrequest = 1'b1;
            CRD:     avs_waitrequest = 1'b0;
            default: avs_waitrequest = 1'b0;
        endcase
    end

    // Single-port RAM, registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            avs_readdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (jtag_wr) begin
                        MonAReg       <= mon_inc;
                        monitor_ready <= 1'b1;
                    end else if (jtag_ld) begin
                        MonAReg <= jdo_addr;
                        if (jdo[34])
                            monitor_error <= 1'b0;
                        if (jdo[35]) begin
                            monitor_ready <= 1'b0;
                            state         <= JRD;
                        end else begin
                            monitor_ready <= 1'b1;
                        end
                    end else if (jtag_nxt) begin
                        MonAReg       <= mon_inc;
                        monitor_ready <= 1'b0;
                        state         <= JRD;
                    end else if (avs_read) begin
                        state <= CRD;
                    end
                end
                JRD: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                    if (jtag_any)
                        monitor_error <= 1'b1;
                end
                CRD: begin
                    avs_readdata <= ram_q;
                    state        <= IDLE;
                    if (jtag_any)
                        monitor_error <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_debug_ocimem.sv
// Scoreboard bench for jtag_debug_ocimem: expected read data is queued when a read
// is issued and compared when the DUT reports completion.
module tb_jtag_debug_ocimem;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    jtag_debug_ocimem #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       sb_q[$];
    logic [31:0]       mdl_mem [0:255];
    logic [ADDR_W-1:0] mdl_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_ld(input logic [7:0] a, input logic clr, input logic rd);
        logic [37:0] j;
        j = '0;
        j[17:10] = a;
        j[34] = clr;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_wr(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic sb_pop_chk(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0)
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else
            chk(tag, obs, sb_q.pop_front());
    endtask

    task automatic jtag_load(input logic [7:0] a, input logic clr);
        jdo = mk_ld(a, clr, 1'b0);
        take_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
        mdl_addr = a;
        chk("ld_ready", 32'(monitor_ready), 32'd1);
        chk("ld_addr", 32'(dut.MonAReg), 32'(mdl_addr));
    endtask

    task automatic jtag_write(input logic [31:0] d);
        jdo = mk_wr(d);
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_b = 1'b0;
        mdl_mem[mdl_addr] = d;
        mdl_addr = mdl_addr + 8'd1;
        chk("wr_ready", 32'(monitor_ready), 32'd1);
    endtask

    task automatic wait_jtag_done(input string tag);
        int n;
        n = 1;
        while (!monitor_ready && n < 16) begin
            cyc();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd2);
        sb_pop_chk(tag, MonDReg);
    endtask

    task automatic jtag_rd_a(input logic [7:0] a);
        mdl_addr = a;
        sb_q.push_back(mdl_mem[a]);
        jdo = mk_ld(a, 1'b0, 1'b1);
        take_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
        chk("rda_busy", 32'(monitor_ready), 32'd0);
        wait_jtag_done("rda");
        chk("rda_addr", 32'(dut.MonAReg), 32'(mdl_addr));
    endtask

    task automatic jtag_rd_nxt();
        mdl_addr = mdl_addr + 8'd1;
        sb_q.push_back(mdl_mem[mdl_addr]);
        take_no_action_ocimem_a = 1'b1;
        cyc();
        take_no_action_ocimem_a = 1'b0;
        chk("rdn_busy", 32'(monitor_ready), 32'd0);
        wait_jtag_done("rdn");
    endtask

    task automatic cpu_read(input logic [7:0] a);
        int n;
        sb_q.push_back(mdl_mem[a]);
        avs_address = a;
        avs_read = 1'b1;
        n = 0;
        @(negedge clk);
        while (avs_waitrequest && n < 16) begin
            cyc();
            n++;
            @(negedge clk);
        end
        chk("crd_wait", 32'(n), 32'd1);
        cyc();
        avs_read = 1'b0;
        sb_pop_chk("crd_data", avs_readdata);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
        int n;
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        n = 0;
        @(negedge clk);
        while (avs_waitrequest && n < 16) begin
            cyc();
            n++;
            @(negedge clk);
        end
        chk("cwr_wait", 32'(n), 32'd0);
        cyc();
        avs_write = 1'b0;
        mdl_mem[a] = d;
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        mdl_addr = '0;
        repeat (3) cyc();

        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", 32'(monitor_ready), 32'd0);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd0);
        chk("rst_addr", 32'(dut.MonAReg), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Load-only address, then three writes
        jtag_load(8'h10, 1'b0);
        chk("ld_mondreg", MonDReg, 32'd0);
        jtag_write(32'hDEADBEEF);
        jtag_write(32'h12345678);
        jtag_write(32'hCAFEF00D);
        chk("wr_addr", 32'(dut.MonAReg), 32'h13);

        // Reads: load-with-read then read-next twice
        jtag_rd_a(8'h10);
        jtag_rd_nxt();
        jtag_rd_nxt();
        chk("rdn_addr", 32'(dut.MonAReg), 32'h12);

        // Address wrap and CPU read of the wrapped location
        jtag_load(8'hFF, 1'b0);
        jtag_write(32'hA5A5A5A5);
        chk("wrap_addr", 32'(dut.MonAReg), 32'h00);
        cpu_read(8'hFF);

        // CPU write colliding with JTAG write: JTAG first, CPU next cycle
        avs_address = 8'h20;
        avs_writedata = 32'h0F0F1234;
        avs_write = 1'b1;
        jdo = mk_wr(32'h55AA3C3C);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        chk("coll_wait_hi", 32'(avs_waitrequest), 32'd1);
        cyc();
        take_action_ocimem_b = 1'b0;
        mdl_mem[mdl_addr] = 32'h55AA3C3C;
        mdl_addr = mdl_addr + 8'd1;
        @(negedge clk);
        chk("coll_wait_lo", 32'(avs_waitrequest), 32'd0);
        cyc();
        avs_write = 1'b0;
        mdl_mem[8'h20] = 32'h0F0F1234;
        chk("coll_addr", 32'(dut.MonAReg), 32'(mdl_addr));
        cpu_read(8'h20);
        jtag_rd_a(8'h00);
        cpu_write(8'h30, 32'h600DF00D);
        jtag_rd_a(8'h30);

        // JTAG pulse during JRD is dropped and flags a sticky error
        mdl_addr = 8'h20;
        sb_q.push_back(mdl_mem[8'h20]);
        jdo = mk_ld(8'h20, 1'b0, 1'b1);
        take_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
        jdo = mk_wr(32'hBAD0BAD0);
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_b = 1'b0;
        chk("drop_error", 32'(monitor_error), 32'd1);
        chk("drop_ready", 32'(monitor_ready), 32'd1);
        sb_pop_chk("drop_data", MonDReg);
        chk("drop_addr", 32'(dut.MonAReg), 32'h20);
        cpu_read(8'h20);
        jtag_load(8'h20, 1'b0);
        chk("err_sticky", 32'(monitor_error), 32'd1);
        jtag_load(8'h20, 1'b1);
        chk("err_clear", 32'(monitor_error), 32'd0);

        // Simultaneous pulses: write wins, load/read ignored
        jdo = mk_wr(32'h7E57C0DE);
        jdo[35] = 1'b1;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mdl_mem[mdl_addr] = 32'h7E57C0DE;
        mdl_addr = mdl_addr + 8'd1;
        chk("prio_addr", 32'(dut.MonAReg), 32'(mdl_addr));
        chk("prio_ready", 32'(monitor_ready), 32'd1);
        jtag_rd_a(8'h20);

        // Reset in the middle of a JTAG read
        jdo = mk_ld(8'h10, 1'b0, 1'b1);
        take_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_mondreg", MonDReg, 32'd0);
        chk("midrst_ready", 32'(monitor_ready), 32'd0);
        chk("midrst_addr", 32'(dut.MonAReg), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        chk("postrst_mondreg", MonDReg, 32'd0);
        chk("postrst_ready", 32'(monitor_ready), 32'd0);
        @(negedge clk);
        chk("postrst_wait", 32'(avs_waitrequest), 32'd0);
        cyc();
        cpu_read(8'h11);
        jtag_rd_a(8'h12);
        jtag_rd_a(8'hFF);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
